decoder_loader: RTL and testbench

DECODER_LOADER -- requirements
Module: decoder_loader

---
 rtl/decoder_loader.sv | 126 ++++++++++++
 tb/tb_decoder_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_loader.sv
// Loads a 2**ADDRESS_WIDTH-entry decoder table from a host byte stream, then reads it
// back through the RAM's synchronous port and compares the sum against the load and host checksums.
`timescale 1ns/1ps
module decoder_loader #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic [DATA_WIDTH-1:0]    byte_i,
    input  logic                     byte_valid_i,
    output logic                     byte_ready_o,
    output logic [ADDRESS_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0]    mem_data_o,
    output logic                     mem_write_enable_o,
    output logic                     mem_clock_enable_o,
    input  logic [DATA_WIDTH-1:0]    mem_data_i,
    input  logic [DATA_WIDTH-1:0]    checksum_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH  = 3'd2,
        VERIFY = 3'd3,
        DRAIN  = 3'd4,
        CHECK  = 3'd5
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = '1;

    state_t                   state_reg;
    logic [ADDRESS_WIDTH-1:0] index_reg;
    logic [ADDRESS_WIDTH-1:0] write_address_reg;
    logic [DATA_WIDTH-1:0]    write_data_reg;
    logic [DATA_WIDTH-1:0]    load_sum_reg;
    logic [DATA_WIDTH-1:0]    read_sum_reg;
    logic                     write_enable_reg;
    logic                     read_pending_reg;
    logic                     done_reg;
    logic                     error_reg;
    logic                     accept;

    assign accept = byte_valid_i & byte_ready_o;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg         <= IDLE;
            index_reg         <= '0;
            write_address_reg <= '0;
            write_data_reg    <= '0;
            load_sum_reg      <= '0;
            read_sum_reg      <= '0;
            write_enable_reg  <= 1'b0;
            read_pending_reg  <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            write_enable_reg <= 1'b0;
            // RAM data lags the VERIFY address by one cycle, so accumulation trails VERIFY by one.
            read_pending_reg <= (state_reg == VERIFY);
            if (read_pending_reg) begin
                read_sum_reg <= read_sum_reg + mem_data_i;
            end
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg    <= LOAD;
                        index_reg    <= '0;
                        load_sum_reg <= '0;
                        read_sum_reg <= '0;
                        done_reg     <= 1'b0;
                        error_reg    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        write_data_reg    <= byte_i;
                        write_address_reg <= index_reg;
                        write_enable_reg  <= 1'b1;
                        index_reg         <= index_reg + 1'b1;
                        load_sum_reg      <= load_sum_reg + byte_i;
                        if (index_reg == LAST_INDEX) begin
                            state_reg <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_reg <= VERIFY;
                end
                VERIFY: begin
                    index_reg <= index_reg + 1'b1;
                    if (index_reg == LAST_INDEX) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_reg <= CHECK;
                end
                CHECK: begin
                    error_reg <= (read_sum_reg != load_sum_reg) | (read_sum_reg != checksum_i);
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o       = (state_reg == LOAD);
    assign mem_clock_enable_o = (state_reg == VERIFY);
    // Read and write share the RAM address: the live index while verifying, the latched write address otherwise.
    assign mem_address_o      = (state_reg == VERIFY) ? index_reg : write_address_reg;
    assign mem_data_o         = write_data_reg;
    assign mem_write_enable_o = write_enable_reg;
    assign busy_o             = (state_reg != IDLE);
    assign done_o             = done_reg;
    assign error_o            = error_reg;

endmodule

// File: tb/tb_decoder_loader.sv
// Scoreboard bench for decoder_loader: a behavioural table RAM, expected writes queued at
// stimulus time and popped on each write strobe, plus read-order and completion checks.
`timescale 1ns/1ps
module tb_decoder_loader;

    logic       clock_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic       byte_valid_i = 1'b0;
    logic       byte_ready_o;
    logic [8:0] mem_address_o;
    logic [7:0] mem_data_o;
    logic       mem_write_enable_o;
    logic       mem_clock_enable_o;
    logic [7:0] mem_data_i;
    logic [7:0] checksum_i = 8'h00;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    always #5 clock_i = ~clock_i;

    decoder_loader #(
        .ADDRESS_WIDTH(9),
        .DATA_WIDTH(8)
    ) dut (
        .clock_i            (clock_i),
        .reset_n_i          (reset_n_i),
        .start_i            (start_i),
        .byte_i             (byte_i),
        .byte_valid_i       (byte_valid_i),
        .byte_ready_o       (byte_ready_o),
        .mem_address_o      (mem_address_o),
        .mem_data_o         (mem_data_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_clock_enable_o (mem_clock_enable_o),
        .mem_data_i         (mem_data_i),
        .checksum_i         (checksum_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .error_o            (error_o)
    );

    // Table RAM with registered read; optional corruption of one entry on write.
    logic [7:0] ram [0:511];
    logic       corrupt = 1'b0;

    always @(posedge clock_i) begin
        if (mem_write_enable_o) begin
            ram[mem_address_o] <= (corrupt && mem_address_o == 9'h1A5) ? ~mem_data_o : mem_data_o;
        end
        if (mem_clock_enable_o) begin
            mem_data_i <= ram[mem_address_o];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb_q[$];
    logic [16:0] sb_entry;
    int          exp_rd = 0;
    int          wr_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clock_i) begin
        if (mem_write_enable_o) begin
            wr_count++;
            check("wr_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_entry = sb_q.pop_front();
                check("wr_addr", 32'(mem_address_o), 32'(sb_entry[16:8]));
                check("wr_data", 32'(mem_data_o), 32'(sb_entry[7:0]));
            end
            check("wr_not_reading", 32'(mem_clock_enable_o), 32'd0);
        end
        if (mem_clock_enable_o) begin
            check("rd_addr", 32'(mem_address_o), 32'(exp_rd[8:0]));
            exp_rd++;
            check("ready_in_verify", 32'(byte_ready_o), 32'd0);
        end
        if (!busy_o) begin
            check("ready_idle", 32'(byte_ready_o), 32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_we"},    32'(mem_write_enable_o), 32'd0);
        check({tag, "_ce"},    32'(mem_clock_enable_o), 32'd0);
        check({tag, "_addr"},  32'(mem_address_o), 32'd0);
        check({tag, "_data"},  32'(mem_data_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_done"},  32'(done_o), 32'd0);
        check({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    task automatic run_seq(input string name, input bit random_valid, input logic [7:0] cks,
                           input logic exp_err, input bit poke, input int abort_at);
        int cyc;
        int sent;
        checksum_i = cks;
        exp_rd     = 0;
        wr_count   = 0;
        sb_q.delete();
        if (poke) begin
            byte_valid_i = 1'b1;
            byte_i       = 8'h3C;
            repeat (4) @(negedge clock_i);
            byte_valid_i = 1'b0;
            check("idle_no_write", 32'(wr_count), 32'd0);
            check("idle_not_busy", 32'(busy_o), 32'd0);
        end
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("done_cleared", 32'(done_o), 32'd0);
        check("error_cleared", 32'(error_o), 32'd0);
        cyc  = 0;
        sent = 0;
        while (!done_o && cyc < 5000) begin
            if (abort_at > 0 && sent == abort_at) break;
            byte_valid_i = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_i       = sent[7:0];
            if (byte_valid_i && byte_ready_o) begin
                sb_q.push_back({sent[8:0], sent[7:0]});
                sent++;
            end
            start_i = poke && (cyc == 700);
            @(negedge clock_i);
            cyc++;
        end
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        if (abort_at > 0) begin
            #2 reset_n_i = 1'b0;
            #1 check_all_zero("abort_reset");
            repeat (2) @(negedge clock_i);
            check_all_zero("abort_hold");
            sb_q.delete();
            reset_n_i = 1'b1;
            wr_count  = 0;
            repeat (5) @(negedge clock_i);
            check("no_strobe_after_reset", 32'(wr_count), 32'd0);
            check("idle_after_reset", 32'(busy_o), 32'd0);
            $display("SEQ %s aborted after %0d bytes", name, sent);
            return;
        end
        check("no_timeout", 32'(cyc < 5000), 32'd1);
        check("done", 32'(done_o), 32'd1);
        check("error", 32'(error_o), 32'(exp_err));
        if (!random_valid) check("done_edge", 32'(cyc), 32'd1027);
        check("writes", 32'(wr_count), 32'd512);
        check("reads", 32'(exp_rd), 32'd512);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clock_i);
        check("done_held", 32'(done_o), 32'd1);
        check("error_held", 32'(error_o), 32'(exp_err));
        check("idle_at_end", 32'(busy_o), 32'd0);
        $display("SEQ %s cycles %0d writes %0d reads %0d error %0b", name, cyc, wr_count, exp_rd, error_o);
    endtask

    initial begin
        reset_n_i = 1'b0;
        repeat (3) @(negedge clock_i);
        check_all_zero("reset");
        reset_n_i = 1'b1;
        repeat (2) @(negedge clock_i);
        check("no_start_idle", 32'(busy_o), 32'd0);

        run_seq("stream_ok",    1'b0, 8'h00, 1'b0, 1'b0, 0);
        run_seq("bad_checksum", 1'b0, 8'h01, 1'b1, 1'b0, 0);
        corrupt = 1'b1;
        run_seq("ram_corrupt",  1'b0, 8'h00, 1'b1, 1'b0, 0);
        corrupt = 1'b0;
        run_seq("random_valid", 1'b1, 8'h00, 1'b0, 1'b0, 0);
        run_seq("reset_abort",  1'b0, 8'h00, 1'b0, 1'b0, 300);
        run_seq("after_reset",  1'b0, 8'h00, 1'b0, 1'b0, 0);
        run_seq("pokes",        1'b0, 8'h00, 1'b0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
